// File: rtl/dbg_arb_pkg.sv
// Shared types for the debug/uP memory arbiter: command encoding, FSM states, field widths.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package dbg_arb_pkg;

  localparam int CMD_W = 2;
  localparam int CH_W  = 3;

  typedef enum logic [CMD_W-1:0] {
    NOP  = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RDPC = 2'b11
  } dbg_cmd_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACQ   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/dbg_chan_mux.sv
// Steers one memory channel either straight from the uP master or from the debug engine.
// Latency: purely combinational, zero cycles in both modes.
// Backpressure: none here; while owned the uP sees done/rdata forced low (stall is driven by the top).
module dbg_chan_mux
  import dbg_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          owned,
  input  logic          dbg_start,
  input  logic          dbg_read,
  input  logic          dbg_write,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic [AW-1:0] up_addr,
  input  logic [DW-1:0] up_wdata,
  input  logic          up_read,
  input  logic          up_write,
  input  logic          up_start,
  output logic [DW-1:0] up_rdata,
  output logic          up_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic          mem_start,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_done
);

  // Select the request source and hide memory responses from the uP while debug owns the port
  always_comb begin
    if (owned) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_read  = dbg_read;
      mem_write = dbg_write;
      mem_start = dbg_start;
      up_rdata  = '0;
      up_done   = 1'b0;
    end else begin
      mem_addr  = up_addr;
      mem_wdata = up_wdata;
      mem_read  = up_read;
      mem_write = up_write;
      mem_start = up_start;
      up_rdata  = mem_rdata;
      up_done   = mem_done;
    end
  end

endmodule

// File: rtl/debug_mem_arbiter.sv
// Serialises single debug RD/WR/RDPC commands onto NCH uP memory ports without breaking uP transfers.
// Latency: uP pass-through adds 0 cycles; debug RDPC/bad-channel completes 2 cycles after accept.
// Backpressure: one command outstanding (dbg_ready low when busy); optional DBG_TIMEOUT_EN WAIT watchdog.
module debug_mem_arbiter
  import dbg_arb_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int TOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCH*AW-1:0]  up_addr,
  input  logic [NCH*DW-1:0]  up_wdata,
  input  logic [NCH-1:0]     up_read,
  input  logic [NCH-1:0]     up_write,
  input  logic [NCH-1:0]     up_start,
  output logic [NCH*DW-1:0]  up_rdata,
  output logic [NCH-1:0]     up_done,
  output logic [NCH-1:0]     up_stall,
  output logic [NCH*AW-1:0]  mem_addr,
  output logic [NCH*DW-1:0]  mem_wdata,
  output logic [NCH-1:0]     mem_read,
  output logic [NCH-1:0]     mem_write,
  output logic [NCH-1:0]     mem_start,
  input  logic [NCH*DW-1:0]  mem_rdata,
  input  logic [NCH-1:0]     mem_done,
  input  logic               dbg_valid,
  input  logic [CMD_W-1:0]   dbg_cmd,
  input  logic [CH_W-1:0]    dbg_ch,
  input  logic [AW-1:0]      dbg_addr,
  input  logic [DW-1:0]      dbg_wdata,
  input  logic [AW-1:0]      dbg_pc,
  output logic               dbg_ready,
  output logic               dbg_rvalid,
  output logic [DW-1:0]      dbg_rdata,
  output logic               dbg_err
);

  // dbg_pc is returned on the data bus, so address and data must share a width
  if (NCH < 1 || NCH > 8 || AW != DW || TOUT < 1 || TOUT > 255) begin : g_param_check
    $error("debug_mem_arbiter: unsupported parameter combination");
  end

  arb_state_e      state;
  dbg_cmd_e        cmd_q;
  logic [CH_W-1:0] ch_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;

  logic [NCH-1:0]  busy;
  logic [NCH-1:0]  sel;
  logic [NCH-1:0]  owned;

  logic            own_phase;
  logic            dbg_start_s;
  logic            dbg_read_s;
  logic            dbg_write_s;
  logic            sel_busy;
  logic            sel_start;
  logic            sel_done;
  logic [DW-1:0]   sel_rdata;

`ifdef DBG_TIMEOUT_EN
  logic [7:0]      wait_cnt;
  logic            wait_expired;
  assign wait_expired = (wait_cnt == 8'(TOUT - 1));
`endif

  // Debug drives the port only in ISSUE/WAIT; ACQ merely stalls the uP while it drains
  assign own_phase   = (state == ISSUE) || (state == WAIT);
  assign dbg_start_s = (state == ISSUE);
  assign dbg_read_s  = own_phase && (cmd_q == RD);
  assign dbg_write_s = own_phase && (cmd_q == WR);

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    assign sel[c]      = (ch_q == CH_W'(c));
    assign owned[c]    = sel[c] && own_phase;
    assign up_stall[c] = sel[c] && ((state == ACQ) || own_phase);

    dbg_chan_mux #(
      .AW(AW),
      .DW(DW)
    ) u_mux (
      .owned     (owned[c]),
      .dbg_start (dbg_start_s),
      .dbg_read  (dbg_read_s),
      .dbg_write (dbg_write_s),
      .dbg_addr  (addr_q),
      .dbg_wdata (wdata_q),
      .up_addr   (up_addr[c*AW +: AW]),
      .up_wdata  (up_wdata[c*DW +: DW]),
      .up_read   (up_read[c]),
      .up_write  (up_write[c]),
      .up_start  (up_start[c]),
      .up_rdata  (up_rdata[c*DW +: DW]),
      .up_done   (up_done[c]),
      .mem_addr  (mem_addr[c*AW +: AW]),
      .mem_wdata (mem_wdata[c*DW +: DW]),
      .mem_read  (mem_read[c]),
      .mem_write (mem_write[c]),
      .mem_start (mem_start[c]),
      .mem_rdata (mem_rdata[c*DW +: DW]),
      .mem_done  (mem_done[c])
    );
  end

  // Pick out the per-channel status bits of the latched target channel
  always_comb begin
    sel_busy  = 1'b0;
    sel_start = 1'b0;
    sel_done  = 1'b0;
    sel_rdata = '0;
    for (int c = 0; c < NCH; c++) begin
      if (sel[c]) begin
        sel_busy  = busy[c];
        sel_start = up_start[c];
        sel_done  = mem_done[c];
        sel_rdata = mem_rdata[c*DW +: DW];
      end
    end
  end

  // Track uP transfers in flight so debug never cuts into one; done beats a same-cycle start
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (mem_done[c]) begin
          busy[c] <= 1'b0;
        end else if (up_start[c] && !owned[c]) begin
          busy[c] <= 1'b1;
        end
      end
`ifdef DBG_TIMEOUT_EN
      if ((state == WAIT) && !sel_done && wait_expired) begin
        busy <= busy & ~sel;
      end
`endif
    end
  end

  // One-outstanding command FSM with registered handshake/result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cmd_q      <= NOP;
      ch_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      dbg_ready  <= 1'b1;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
      dbg_err    <= 1'b0;
`ifdef DBG_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      dbg_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (dbg_valid && (dbg_cmd != NOP)) begin
            cmd_q     <= dbg_cmd_e'(dbg_cmd);
            ch_q      <= dbg_ch;
            addr_q    <= dbg_addr;
            wdata_q   <= dbg_wdata;
            dbg_ready <= 1'b0;
            dbg_rdata <= '0;
            dbg_err   <= 1'b0;
            if (dbg_cmd == RDPC) begin
              dbg_rdata <= DW'(dbg_pc);
              state     <= RESP;
            end else if (int'(dbg_ch) >= NCH) begin
              dbg_err <= 1'b1;
              state   <= RESP;
            end else begin
              state <= ACQ;
            end
          end
        end
        ACQ: begin
          if (!sel_busy && !sel_start) begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef DBG_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          if (sel_done) begin
            dbg_rdata <= (cmd_q == RD) ? sel_rdata : '0;
            state     <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (sel_done) begin
            dbg_rdata <= (cmd_q == RD) ? sel_rdata : '0;
            state     <= RESP;
          end
`ifdef DBG_TIMEOUT_EN
          else if (wait_expired) begin
            dbg_err <= 1'b1;
            state   <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        RESP: begin
          dbg_rvalid <= 1'b1;
          dbg_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          dbg_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_mem_arbiter.sv
// Directed bench for debug_mem_arbiter (NCH=2, AW=DW=32, TOUT=10).
// Latency: inputs driven 1 time unit after the rising edge, outputs checked before the next edge.
// Backpressure: memory done/rdata are driven by hand per scenario; DBG_TIMEOUT_EN adds a watchdog case.
module tb_debug_mem_arbiter;
  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic              clk;
  logic              reset;
  logic [NCH*AW-1:0] up_addr;
  logic [NCH*DW-1:0] up_wdata;
  logic [NCH-1:0]    up_read;
  logic [NCH-1:0]    up_write;
  logic [NCH-1:0]    up_start;
  logic [NCH*DW-1:0] up_rdata;
  logic [NCH-1:0]    up_done;
  logic [NCH-1:0]    up_stall;
  logic [NCH*AW-1:0] mem_addr;
  logic [NCH*DW-1:0] mem_wdata;
  logic [NCH-1:0]    mem_read;
  logic [NCH-1:0]    mem_write;
  logic [NCH-1:0]    mem_start;
  logic [NCH*DW-1:0] mem_rdata;
  logic [NCH-1:0]    mem_done;
  logic              dbg_valid;
  logic [1:0]        dbg_cmd;
  logic [2:0]        dbg_ch;
  logic [AW-1:0]     dbg_addr;
  logic [DW-1:0]     dbg_wdata;
  logic [AW-1:0]     dbg_pc;
  logic              dbg_ready;
  logic              dbg_rvalid;
  logic [DW-1:0]     dbg_rdata;
  logic              dbg_err;

  int n_checks = 0;
  int n_fail   = 0;

  debug_mem_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .TOUT(10)) dut (
    .clk(clk), .reset(reset),
    .up_addr(up_addr), .up_wdata(up_wdata), .up_read(up_read), .up_write(up_write),
    .up_start(up_start), .up_rdata(up_rdata), .up_done(up_done), .up_stall(up_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_start(mem_start), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .dbg_valid(dbg_valid), .dbg_cmd(dbg_cmd), .dbg_ch(dbg_ch), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_pc(dbg_pc), .dbg_ready(dbg_ready), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata), .dbg_err(dbg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one command for a single cycle (accepted at the next edge when in IDLE)
  task automatic dbg_send(input logic [1:0] cmd, input logic [2:0] ch,
                          input logic [31:0] addr, input logic [31:0] wdata);
    dbg_valid = 1'b1;
    dbg_cmd   = cmd;
    dbg_ch    = ch;
    dbg_addr  = addr;
    dbg_wdata = wdata;
    step();
    dbg_valid = 1'b0;
    dbg_cmd   = 2'b00;
    dbg_addr  = '0;
    dbg_wdata = '0;
  endtask

  initial begin
    reset = 1'b1;
    up_addr = '0; up_wdata = '0; up_read = '0; up_write = '0; up_start = '0;
    mem_rdata = '0; mem_done = '0;
    dbg_valid = 1'b0; dbg_cmd = 2'b00; dbg_ch = '0; dbg_addr = '0; dbg_wdata = '0; dbg_pc = '0;
    step();
    step();
    reset = 1'b0;

    // Reset values
    check("rst_ready",  64'(dbg_ready),  64'h1);
    check("rst_rvalid", 64'(dbg_rvalid), 64'h0);
    check("rst_err",    64'(dbg_err),    64'h0);
    check("rst_rdata",  64'(dbg_rdata),  64'h0);
    check("rst_stall",  64'(up_stall),   64'h0);

    // Pass-through with zero latency
    up_addr[31:0] = 32'h0000_0100; up_read = 2'b01; mem_rdata[31:0] = 32'hAAAA_5555; mem_done = 2'b01;
    #1;
    check("pt_addr",  64'(mem_addr[31:0]), 64'h100);
    check("pt_read",  64'(mem_read),       64'h1);
    check("pt_rdata", 64'(up_rdata[31:0]), 64'hAAAA_5555);
    check("pt_done",  64'(up_done),        64'h1);
    up_addr = '0; up_read = '0; mem_rdata = '0; mem_done = '0;
    step();

    // NOP is ignored
    dbg_send(2'b00, 3'd0, 32'h0, 32'h0);
    check("nop_ready", 64'(dbg_ready), 64'h1);

    // 1: RD ch1 @0x40, done 3 cycles after start
    dbg_send(2'b01, 3'd1, 32'h40, 32'h0);
    check("rd_acq_ready", 64'(dbg_ready), 64'h0);
    check("rd_acq_stall", 64'(up_stall),  64'h2);
    check("rd_acq_start", 64'(mem_start), 64'h0);
    step();
    check("rd_iss_start", 64'(mem_start),         64'h2);
    check("rd_iss_read",  64'(mem_read),          64'h2);
    check("rd_iss_addr",  64'(mem_addr[63:32]),   64'h40);
    step();
    check("rd_wait_start", 64'(mem_start), 64'h0);
    check("rd_wait_read",  64'(mem_read),  64'h2);
    step();
    step();
    mem_done = 2'b10; mem_rdata[63:32] = 32'hDEAD_BEEF;
    #1;
    check("rd_own_updone",  64'(up_done),          64'h0);
    check("rd_own_uprdata", 64'(up_rdata[63:32]),  64'h0);
    step();
    mem_done = '0; mem_rdata = '0;
    check("rd_resp_rvalid", 64'(dbg_rvalid), 64'h0);
    check("rd_resp_stall",  64'(up_stall),   64'h0);
    step();
    check("rd_rvalid", 64'(dbg_rvalid), 64'h1);
    check("rd_rdata",  64'(dbg_rdata),  64'hDEAD_BEEF);
    check("rd_err",    64'(dbg_err),    64'h0);
    check("rd_ready",  64'(dbg_ready),  64'h1);
    step();
    check("rd_rvalid_pulse", 64'(dbg_rvalid), 64'h0);
    check("rd_rdata_hold",   64'(dbg_rdata),  64'hDEAD_BEEF);

    // 2: uP transfer pending on ch0, then debug WR ch0
    up_start = 2'b01; up_read = 2'b01; up_addr[31:0] = 32'h200;
    step();
    up_start = '0;
    dbg_send(2'b10, 3'd0, 32'h80, 32'hCAFE_F00D);
    check("wr_acq_stall", 64'(up_stall),  64'h1);
    check("wr_acq_start", 64'(mem_start), 64'h0);
    step();
    step();
    check("wr_hold_start", 64'(mem_start), 64'h0);
    mem_done = 2'b01; mem_rdata[31:0] = 32'h1111_2222;
    #1;
    check("wr_up_done", 64'(up_done), 64'h1);
    step();
    mem_done = '0; up_read = '0; up_addr = '0;
    check("wr_acq_last", 64'(mem_start), 64'h0);
    step();
    check("wr_iss_start", 64'(mem_start),        64'h1);
    check("wr_iss_write", 64'(mem_write),        64'h1);
    check("wr_iss_read",  64'(mem_read),         64'h0);
    check("wr_iss_wdata", 64'(mem_wdata[31:0]),  64'hCAFE_F00D);
    check("wr_iss_addr",  64'(mem_addr[31:0]),   64'h80);
    mem_done = 2'b01;
    step();
    mem_done = '0; mem_rdata = '0;
    check("wr_resp_write", 64'(mem_write), 64'h0);
    step();
    check("wr_rvalid", 64'(dbg_rvalid), 64'h1);
    check("wr_rdata",  64'(dbg_rdata),  64'h0);
    check("wr_err",    64'(dbg_err),    64'h0);

    // 3: RDPC
    dbg_pc = 32'h1234;
    dbg_send(2'b11, 3'd0, 32'h0, 32'h0);
    dbg_pc = '0;
    check("pc_c1_rvalid", 64'(dbg_rvalid), 64'h0);
    check("pc_c1_start",  64'(mem_start),  64'h0);
    step();
    check("pc_rvalid", 64'(dbg_rvalid), 64'h1);
    check("pc_rdata",  64'(dbg_rdata),  64'h1234);
    check("pc_start",  64'(mem_start),  64'h0);

    // 4: bad channel
    dbg_send(2'b01, 3'd5, 32'h10, 32'h0);
    check("bad_start", 64'(mem_start), 64'h0);
    check("bad_read",  64'(mem_read),  64'h0);
    check("bad_stall", 64'(up_stall),  64'h0);
    step();
    check("bad_rvalid", 64'(dbg_rvalid), 64'h1);
    check("bad_err",    64'(dbg_err),    64'h1);

    // 5: reset during WAIT
    dbg_send(2'b01, 3'd1, 32'h44, 32'h0);
    step();
    step();
    check("rst_wait_stall", 64'(up_stall), 64'h2);
    reset = 1'b1;
    step();
    check("rst_mid_ready", 64'(dbg_ready),  64'h1);
    check("rst_mid_stall", 64'(up_stall),   64'h0);
    check("rst_mid_read",  64'(mem_read),   64'h0);
    check("rst_mid_err",   64'(dbg_err),    64'h0);
    reset = 1'b0;
    up_addr[63:32] = 32'h55; up_read = 2'b10;
    #1;
    check("rst_pt_read", 64'(mem_read),         64'h2);
    check("rst_pt_addr", 64'(mem_addr[63:32]),  64'h55);
    up_addr = '0; up_read = '0;
    step();

`ifdef DBG_TIMEOUT_EN
    // 6: watchdog, no done ever arrives
    begin
      int cyc = 0;
      dbg_send(2'b01, 3'd0, 32'h8, 32'h0);
      while (!dbg_rvalid && cyc < 40) begin
        step();
        cyc++;
      end
      // ACQ(accept edge) -> ISSUE -> 10 WAIT -> RESP -> rvalid: 13 edges after accept
      check("tout_cycles", 64'(cyc),        64'd13);
      check("tout_rvalid", 64'(dbg_rvalid), 64'h1);
      check("tout_err",    64'(dbg_err),    64'h1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
